// File: rtl/rv_fetch_if.sv
// rtl/rv_fetch_if.sv - instruction memory read bus between fetch and memory
interface rv_fetch_if;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i;
    logic        im_valid_i;

    modport master (output im_addr_o, output im_rd_o, input im_data_i, input im_valid_i);
    modport slave  (input im_addr_o, input im_rd_o, output im_data_i, output im_valid_i);
endinterface

// File: rtl/rv_fetch.sv
// rtl/rv_fetch.sv - uRV fetch stage: pc, single-outstanding imem reads, redirect, skid buffer
module rv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        f_stall_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_bra_target_i,
    rv_fetch_if.master  im,
    output logic [31:0] f_pc_o,
    output logic [31:0] f_ir_o,
    output logic        f_valid_o
);
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_pending;
    logic        r_discard;
    logic        r_run;
    logic [31:0] r_s_pc;
    logic [31:0] r_s_ir;
    logic        r_s_full;
    logic [31:0] r_f_pc;
    logic [31:0] r_f_ir;
    logic        r_f_valid;

    logic        w_issue;
    logic        w_resp;

    // A new request may go out in the same cycle the previous response lands.
    always_comb begin
        w_issue = r_run && !r_s_full && !f_stall_i && !x_bra_i
                  && (!r_pending || im.im_valid_i);
        w_resp  = im.im_valid_i && r_pending && !r_discard;
    end

    assign im.im_rd_o   = w_issue;
    assign im.im_addr_o = r_pc;

    assign f_pc_o    = r_f_pc;
    assign f_ir_o    = r_f_ir;
    assign f_valid_o = r_f_valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc      <= RESET_VECTOR;
            r_req_pc  <= RESET_VECTOR;
            r_pending <= 1'b0;
            r_discard <= 1'b0;
            r_run     <= 1'b0;
            r_s_pc    <= 32'h0;
            r_s_ir    <= 32'h0;
            r_s_full  <= 1'b0;
            r_f_pc    <= RESET_VECTOR;
            r_f_ir    <= 32'h0;
            r_f_valid <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (x_bra_i) begin
                // A response landing now is dropped; one still in flight is marked stale.
                r_pc      <= {x_bra_target_i[31:2], 2'b00};
                r_s_full  <= 1'b0;
                r_f_valid <= 1'b0;
                r_pending <= r_pending && !im.im_valid_i;
                r_discard <= r_pending && !im.im_valid_i;
            end else begin
                if (w_issue) begin
                    r_req_pc  <= r_pc;
                    r_pc      <= r_pc + 32'd4;
                    r_pending <= 1'b1;
                end else if (im.im_valid_i) begin
                    r_pending <= 1'b0;
                end

                if (im.im_valid_i && r_discard)
                    r_discard <= 1'b0;

                if (w_resp && !f_stall_i) begin
                    r_f_pc    <= r_req_pc;
                    r_f_ir    <= im.im_data_i;
                    r_f_valid <= 1'b1;
                end else if (w_resp) begin
                    r_s_pc   <= r_req_pc;
                    r_s_ir   <= im.im_data_i;
                    r_s_full <= 1'b1;
                end else if (!f_stall_i && r_s_full) begin
                    r_f_pc    <= r_s_pc;
                    r_f_ir    <= r_s_ir;
                    r_f_valid <= 1'b1;
                    r_s_full  <= 1'b0;
                end else if (!f_stall_i) begin
                    r_f_valid <= 1'b0;
                end
            end
        end
    end
endmodule
